// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit owning the HI/LO registers.
// One cycle of operand prep, 32 shift-add or restoring-divide steps, one cycle of sign fix-up.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        is_div;
    logic        is_signed;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        q_bit;
    logic [31:0] rem_new;
    logic [63:0] prod_fix;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];

    // Multiply: opa is the multiplicand, opb the multiplier shifted right each step.
    // Divide: opa is the dividend shifted left into the remainder, opb the divisor.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (opb_q[0] ? opa_q : 32'd0)};
        rem_sh   = {acc_q[63:32], opa_q[31]};
        q_bit    = (rem_sh >= {1'b0, opb_q});
        rem_new  = q_bit ? (rem_sh[31:0] - opb_q) : rem_sh[31:0];
        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            op_d    = op[1:0];
                            a_d     = A;
                            b_d     = B;
                            state_d = PREP;
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            PREP: begin
                opa_d     = (is_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
                opb_d     = (is_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
                neg_res_d = is_signed & (a_q[31] ^ b_q[31]);
                neg_rem_d = is_signed & a_q[31];
                acc_d     = 64'd0;
                cnt_d     = 5'd0;
                state_d   = RUN;
            end
            RUN: begin
                if (is_div) begin
                    acc_d = {rem_new, acc_q[30:0], q_bit};
                    opa_d = {opa_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                    opb_d = {1'b0, opb_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!is_div) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (b_q == 32'd0) begin
                    // Divide by zero reports the untouched dividend, even for signed DIV.
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    lo_d = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                    hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= 2'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 5'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural HI/LO effect of one instruction, straight from the ISA definition.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] h, inout logic [31:0] l);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            3'd1: begin q = sa * sb; p = q; h = p[63:32]; l = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    l = a / b; h = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    p = q; l = p[31:0];
                    p = r; h = p[31:0];
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endtask

    // Called on a falling edge; returns on the falling edge after the result is visible.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at);
        int n;
        bit stable;
        logic [31:0] eh, el;
        eh = hi_m;
        el = lo_m;
        model(o, a, b, eh, el);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
        if (o > 3'd3) begin
            check("mt_busy", 64'(busy), 64'd0);
            check("mt_done", 64'(done), 64'd0);
        end else begin
            n = 0;
            stable = 1'b1;
            while (busy && n < 100) begin
                if (done || hi !== hi_m || lo !== lo_m) stable = 1'b0;
                n++;
                if (n == inject_at) begin
                    start = 1'b1; op = 3'd5; A = 32'hDEAD_BEEF;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check("busy_len", 64'(n), 64'd34);
            check("hold", 64'(stable), 64'd1);
            check("done", 64'(done), 64'd1);
        end
        hi_m = eh;
        lo_m = el;
        check("hi", 64'(hi), 64'(hi_m));
        check("lo", 64'(lo), 64'(lo_m));
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h (exp %08h %08h)",
                 o, a, b, hi, lo, hi_m, lo_m);
    endtask

    initial begin
        int k;
        bit no_done;
        logic [31:0] ra, rb;
        logic [2:0]  ro;

        // Reset with a start/MTHI request held high: must be ignored.
        rst = 1'b0; start = 1'b1; op = 3'd4; A = 32'h0000_FFFF;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check("post_rst_hi", 64'(hi), 64'd0);

        do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_lo_const", 64'(lo), 64'd1);
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);

        do_op(3'd1, 32'hFFFF_FFFD, 32'd7, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        check("mult_min_hi", 64'(hi), 64'h4000_0000);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        do_op(3'd2, 32'd100, 32'd7, 0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_wrap_lo", 64'(lo), 64'h8000_0000);
        do_op(3'd2, 32'd5, 32'd0, 0);
        do_op(3'd3, 32'hFFFF_FFF0, 32'd0, 0);
        check("div0_signed_hi", 64'(hi), 64'hFFFF_FFF0);

        @(negedge clk);
        do_op(3'd4, 32'h0000_1234, 32'd0, 0);
        do_op(3'd5, 32'h0000_5678, 32'd0, 0);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);

        // MTLO pulsed mid-RUN is ignored; the following start is back-to-back in the done cycle.
        do_op(3'd0, 32'd3, 32'd4, 10);
        check("inject_lo", 64'(lo), 64'd12);
        do_op(3'd2, 32'h0001_0000, 32'd3, 0);

        // Reset during a divide: no partial result, no done pulse.
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = $urandom; B = $urandom | 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) no_done = 1'b0;
        end
        check("midrst_quiet", 64'(no_done), 64'd1);
        hi_m = 32'd0;
        lo_m = 32'd0;
        do_op(3'd0, 32'd2, 32'd3, 0);

        for (k = 0; k < 25; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'd1;
                3:       rb = $urandom_range(1, 100);
                default: rb = $urandom;
            endcase
            @(negedge clk);
            do_op(ro, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS150 datapath, handling the operations the combinational ALU does not: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It owns the architectural HI/LO registers.
- The execute stage issues an operation with a one-cycle `start` strobe and reads HI/LO directly for MFHI/MFLO.
- The control unit stalls on `busy`.

## Interface
- No parameters; datapath width fixed at 32 bits, iteration count fixed at 32.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  issue strobe; sampled only when busy=0
- op  in  3  0=MULTU, 1=MULT, 2=DIVU, 3=DIV, 4=MTHI, 5=MTLO, 6/7 reserved (ignored)
- A  in  32  rs operand (multiplicand / dividend / MTHI-MTLO source)
- B  in  32  rt operand (multiplier / divisor)
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse when HI/LO receive a mul/div result
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, PREP, RUN, FIX.
- **IDLE**
  - start=1 with op 0–3: latch op, A and B; go to PREP.
  - start=1 with op=4: `hi<=A` that edge; stay IDLE. op=5 writes `lo<=A` the same way.
  - Reserved ops: no effect.
- **PREP** (1 cycle)
  - Signed ops: form absolute values of A and B; record the result signs.
    - Product/quotient sign = A[31]^B[31].
    - Remainder sign = A[31].
  - Unsigned ops: use operands as-is.
  - Clear the 64-bit accumulator and set the iteration counter to 0. Go to RUN.
- **RUN** (32 cycles)
  - Multiply, radix-2 shift-add: if multiplier LSB is set, add multiplicand to the upper accumulator half; shift right by one, capturing the carry.
  - Divide, restoring: shift the {rem, quot} pair left; trial-subtract the divisor from rem; if the result is non-negative (33-bit compare), commit it and set quot LSB.
  - After iteration 31, go to FIX.
- **FIX** (1 cycle)
  - Apply sign correction: two's-complement negate the 64-bit product, the quotient and/or the remainder as recorded.
  - Multiply writes `{hi,lo}<=product`. Divide writes `lo<=quotient`, `hi<=remainder`.
  - Assert done; go to IDLE.
- **Divide by zero**: full latency still applies.
  - DIVU: lo=0xFFFFFFFF, hi=A.
  - DIV: lo=0xFFFFFFFF, hi=A (original signed A, no sign correction).
- **DIV 0x80000000 / 0xFFFFFFFF**: lo=0x80000000, hi=0 (natural wrap; no trap).
- HI/LO hold their previous values for the whole operation and change only in FIX, or on MTHI/MTLO.
- Arithmetic is modulo 2^64 for products and modulo 2^32 for quotient/remainder. No overflow flag.

## Timing
- Reset (rst=0 at an edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset aborts any operation in flight; a partial result is never written.
- start accepted at edge E0:
  - busy=1 after E0 through E33 (34 cycles).
  - After E34: hi/lo valid, done=1 for exactly one cycle, busy=0.
- A new start may be asserted in the cycle done=1. It is accepted at E35, giving back-to-back operations at a 35-cycle pitch.
- start while busy=1 is ignored. A, B and op are don't-care after E0.
- MTHI/MTLO: result visible the cycle after the edge; busy and done stay 0.
- Simultaneous rst=0 and start=1: reset wins.

## Test plan
- **Reset**: hold rst=0 two cycles, then release.
  - -> hi=0, lo=0, busy=0, done=0.
  - start ignored while rst=0.
- **MULTU 0xFFFFFFFF×0xFFFFFFFF**
  - -> after E34: hi=0xFFFFFFFE, lo=0x00000001, single done pulse.
  - busy high exactly 34 cycles.
- **MULT, signed products**
  - 0xFFFFFFFD(−3)×7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
- **DIV / DIVU**
  - DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 -> lo=14, hi=2.
  - DIV 0x80000000/−1 -> lo=0x80000000, hi=0.
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- **MTHI/MTLO and start-while-busy**
  - MTHI 0x1234, then MTLO 0x5678 -> hi/lo update next cycle, no busy.
  - Start MULTU 3×4, and pulse start with op=5 mid-RUN -> ignored. Final hi=0, lo=12.
  - Back-to-back start in the done cycle -> accepted.
- **Reset mid-RUN**
  - Start DIVU, then rst=0 at iteration 10 -> hi=lo=0, busy=0, no done pulse.
  - A following MULTU 2×3 -> lo=6.
